// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO page
// holding a 64-bit cycle counter, a compare/interrupt register and a byte TX FIFO.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = FW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  localparam logic [9:0] OFF_CYC_LO = 10'h000;
  localparam logic [9:0] OFF_CYC_HI = 10'h001;
  localparam logic [9:0] OFF_TX     = 10'h002;
  localparam logic [9:0] OFF_STATUS = 10'h003;
  localparam logic [9:0] OFF_CMP    = 10'h004;

  logic [31:0]   r_mem  [DEPTH_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [63:0]   r_cycle;
  logic [31:0]   r_cmp;
  logic          r_cmp_hit;
  logic          r_overflow;
  logic [FW-1:0] r_head;
  logic [FW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [AW-1:0] w_word;
  logic [9:0]    w_off;
  logic          w_mmio_wr;
  logic          w_push_req;
  logic          w_status_wr;
  logic          w_cmp_wr;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_unused_addr;

  assign w_ram_hit     = (ALUResult < RAM_BYTES);
  assign w_mmio_hit    = (ALUResult[31:12] == MMIO_BASE[31:12]);
  assign w_word        = ALUResult[AW+1:2];
  assign w_off         = ALUResult[11:2];
  assign w_unused_addr = ^ALUResult[1:0];

  assign w_mmio_wr   = MemWrite & w_mmio_hit;
  assign w_push_req  = w_mmio_wr & (w_off == OFF_TX);
  assign w_status_wr = w_mmio_wr & (w_off == OFF_STATUS);
  assign w_cmp_wr    = w_mmio_wr & (w_off == OFF_CMP);

  assign tx_valid = (r_count != '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_pop    = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_push   = w_push_req & (~w_full | w_pop);
  assign tx_data  = tx_valid ? r_fifo[r_head] : 8'h00;
  assign irq      = r_cmp_hit;

  // RAM and FIFO storage survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_hit) r_mem[w_word] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_tail] <= WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle    <= '0;
      r_cmp      <= 32'hFFFF_FFFF;
      r_cmp_hit  <= 1'b0;
      r_overflow <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;

      if (w_cmp_wr) r_cmp <= WriteData;

      // Compare hit takes priority over a software clear in the same cycle.
      if (r_cycle[31:0] == r_cmp)              r_cmp_hit <= 1'b1;
      else if (w_status_wr && WriteData[2])    r_cmp_hit <= 1'b0;

      if (w_push_req && !w_push)               r_overflow <= 1'b1;
      else if (w_status_wr && WriteData[3])    r_overflow <= 1'b0;

      if (w_pop)  r_head <= r_head + FW'(1);
      if (w_push) r_tail <= r_tail + FW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (w_ram_hit) begin
      ReadData = r_mem[w_word];
    end else if (w_mmio_hit) begin
      case (w_off)
        OFF_CYC_LO: ReadData = r_cycle[31:0];
        OFF_CYC_HI: ReadData = r_cycle[63:32];
        OFF_STATUS: ReadData = {23'h0, 5'(r_count), r_overflow, r_cmp_hit,
                                ~tx_valid, w_full};
        OFF_CMP:    ReadData = r_cmp;
        default:    ReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: decode/RAM vector table
// plus hand-written FIFO, compare and async-reset sequences.
module tb_data_mem_responder;

  localparam logic [31:0] A_CYC_LO = 32'h8000_0000;
  localparam logic [31:0] A_CYC_HI = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;
  localparam logic [31:0] A_CMP    = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  data_mem_responder #(
    .DEPTH_WORDS(64),
    .FIFO_DEPTH (4),
    .MMIO_BASE  (32'h8000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rexp;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge and the task returns at the following negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    ALUResult = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemWrite  = 1'b0;
    ALUResult = a;
    #1;
    d = ReadData;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] c;
    logic [7:0]  exp_bytes [4];
    int          seen;
    int          irq_cnt;

    tbl[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 32'h1111_1111};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h0000_0013, 32'h0000_1234, 32'h0000_0010, 32'h0000_1234};
    tbl[3]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_0001, 32'h0000_00FE, 32'hA5A5_0001};
    tbl[4]  = '{1'b1, 32'h0000_0100, 32'h0000_FFFF, 32'h0000_0100, 32'h0000_0000};
    tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h1111_1111};
    tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0300, 32'h0000_0000};
    tbl[7]  = '{1'b1, A_CYC_HI,      32'h0000_0055, A_CYC_HI,      32'h0000_0000};
    tbl[8]  = '{1'b1, 32'h8000_0014, 32'h0000_1234, 32'h8000_0014, 32'h0000_0000};
    tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, A_CMP,         32'hFFFF_FFFF};
    tbl[10] = '{1'b1, A_CMP,         32'h00AB_CDEF, A_CMP,         32'h00AB_CDEF};
    tbl[11] = '{1'b1, A_CMP,         32'hFFFF_FFFF, 32'h8000_1010, 32'h0000_0000};
    tbl[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_F010, 32'h0000_0000};
    tbl[13] = '{1'b0, 32'h0000_0000, 32'h0000_0000, A_TX,          32'h0000_0000};

    // Reset state
    #2;
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(A_STATUS, v);
    chk("rst_status", v, 32'h0000_0002);
    repeat (10) @(negedge clk);
    rd(A_CYC_LO, v);
    chk("cyc_lo_10", v, 32'd10);
    rd(A_CYC_HI, v);
    chk("cyc_hi_0", v, 32'd0);
    @(negedge clk);

    // Decode / RAM vector table
    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].we) wr(tbl[i].waddr, tbl[i].wdata);
      else @(negedge clk);
      rd(tbl[i].raddr, v);
      chk($sformatf("vec%0d", i), v, tbl[i].rexp);
    end
    @(negedge clk);

    // FIFO overflow with console stalled
    tx_ready = 1'b0;
    wr(A_TX, 32'h41); wr(A_TX, 32'h42); wr(A_TX, 32'h43); wr(A_TX, 32'h44);
    wr(A_TX, 32'h45);
    rd(A_STATUS, v);
    chk("ovf_status", v, 32'h0000_0049);
    repeat (3) @(negedge clk);
    chk("stall_tx_data", {24'h0, tx_data}, 32'h41);
    exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43; exp_bytes[3] = 8'h44;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), {31'h0, tx_valid}, 32'h1);
      chk($sformatf("drain%0d_data", i), {24'h0, tx_data}, {24'h0, exp_bytes[i]});
      @(negedge clk);
    end
    chk("drain_empty_valid", {31'h0, tx_valid}, 32'h0);
    chk("drain_empty_data", {24'h0, tx_data}, 32'h0);
    tx_ready = 1'b0;
    @(negedge clk);
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, v);
    chk("ovf_clear", v, 32'h0000_0002);
    @(negedge clk);

    // Full FIFO with simultaneous pop and push
    wr(A_TX, 32'h61); wr(A_TX, 32'h62); wr(A_TX, 32'h63); wr(A_TX, 32'h64);
    MemWrite  = 1'b1;
    ALUResult = A_TX;
    WriteData = 32'h55;
    tx_ready  = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    tx_ready = 1'b0;
    rd(A_STATUS, v);
    chk("full_pushpop_status", v, 32'h0000_0041);
    @(negedge clk);
    exp_bytes[0] = 8'h62; exp_bytes[1] = 8'h63; exp_bytes[2] = 8'h64; exp_bytes[3] = 8'h55;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_drain%0d_data", i), {24'h0, tx_data}, {24'h0, exp_bytes[i]});
      @(negedge clk);
    end
    tx_ready = 1'b0;
    rd(A_STATUS, v);
    chk("pp_final_status", v, 32'h0000_0002);

    // Compare / interrupt from a fresh reset
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    wr(A_CMP, 32'd20);
    seen = 0;
    c = 32'h0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      rd(A_CYC_LO, c);
      if (irq) seen = 1;
      else @(negedge clk);
    end
    chk("irq_seen", {31'h0, irq}, 32'h1);
    chk("irq_rise_cycle", c, 32'd21);
    rd(A_STATUS, v);
    chk("cmp_status", v, 32'h0000_0006);
    @(negedge clk);
    wr(A_STATUS, 32'h4);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    irq_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (irq) irq_cnt++;
    end
    chk("irq_stays_low", irq_cnt, 32'd0);

    // Compare hit beats a same-cycle clear
    rd(A_CYC_LO, c);
    MemWrite  = 1'b1;
    ALUResult = A_CMP;
    WriteData = c + 32'd2;
    @(negedge clk);
    MemWrite = 1'b0;
    @(negedge clk);
    MemWrite  = 1'b1;
    ALUResult = A_STATUS;
    WriteData = 32'h4;
    @(negedge clk);
    MemWrite = 1'b0;
    chk("set_wins_irq", {31'h0, irq}, 32'h1);

    // Async reset mid-drain
    @(negedge clk);
    wr(A_TX, 32'h71); wr(A_TX, 32'h72); wr(A_TX, 32'h73); wr(A_TX, 32'h74);
    tx_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("mid_drain_data", {24'h0, tx_data}, 32'h72);
    reset = 1'b0;
    #1;
    chk("async_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("async_tx_data", {24'h0, tx_data}, 32'h0);
    chk("async_irq", {31'h0, irq}, 32'h0);
    tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rd(A_STATUS, v);
    chk("post_rst_status", v, 32'h0000_0002);
    rd(A_CMP, v);
    chk("post_rst_cmp", v, 32'hFFFF_FFFF);
    rd(32'h0000_0010, v);
    chk("post_rst_ram", v, 32'h0000_1234);
    rd(32'h0000_00FC, v);
    chk("post_rst_ram_top", v, 32'hA5A5_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
